// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM encodings,
// default multiply/divide latency and counter widths.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    localparam int MD_LAT_DEFAULT = 4;
    localparam int CNT_W          = 4;
    localparam int PERF_W         = 32;

endpackage

// File: rtl/md_lat_counter.sv
// Loadable down-counter that times the remaining EX cycles of a multiply/divide.
module md_lat_counter
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: multiply/divide freeze > load-use stall > branch flush.
// Optional performance counters are enabled with macro PIPE_CTRL_PERF_EN.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_use,
    input  logic              B_Taken,
    input  logic              E_MD,
    output logic              PC_En,
    output logic              IF_ID_En,
    output logic              IF_ID_Flush,
    output logic              ID_EX_En,
    output logic              ID_EX_Flush,
    output logic              EX_MEM_Flush,
    output logic              MD_Busy,
    output logic              MD_Done,
    output logic [PERF_W-1:0] Stall_Cnt,
    output logic [PERF_W-1:0] Flush_Cnt
);

    // The first EX cycle is spent in RUN, the last one in MD_WAIT with cnt==0.
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 2);

    state_e state_q;
    state_e state_d;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;

    md_lat_counter u_md_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (MD_LOAD),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (E_MD)     state_d = MD_WAIT;
            MD_WAIT: if (cnt_zero) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Outputs are forced to their idle values while rst is high so an
    // aborted sequence never shows a freeze or a Done pulse.
    always_comb begin
        PC_En        = 1'b1;
        IF_ID_En     = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_En     = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        MD_Busy      = 1'b0;
        MD_Done      = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (E_MD) begin
                        PC_En        = 1'b0;
                        IF_ID_En     = 1'b0;
                        ID_EX_En     = 1'b0;
                        EX_MEM_Flush = 1'b1;
                        cnt_load     = 1'b1;
                    end else if (load_use) begin
                        PC_En       = 1'b0;
                        IF_ID_En    = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end else if (B_Taken) begin
                        IF_ID_Flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (cnt_zero) begin
                        MD_Done = 1'b1;
                    end else begin
                        PC_En        = 1'b0;
                        IF_ID_En     = 1'b0;
                        ID_EX_En     = 1'b0;
                        EX_MEM_Flush = 1'b1;
                        MD_Busy      = 1'b1;
                        cnt_dec      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + PERF_W'(!PC_En);
            flush_cnt_q <= flush_cnt_q + PERF_W'(IF_ID_Flush);
        end
    end

    assign Stall_Cnt = stall_cnt_q;
    assign Flush_Cnt = flush_cnt_q;
`else
    assign Stall_Cnt = '0;
    assign Flush_Cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: three instances (MD_LAT 4, 2, 6) share stimulus and
// are checked against an elapsed-cycle reference model, vector tables and corner sequences.
module tb_pipe_stall_ctrl;

    localparam int NI = 3;
    localparam int LATS [NI] = '{4, 2, 6};

    // Output vector order: PC_En, IF_ID_En, IF_ID_Flush, ID_EX_En,
    //                      ID_EX_Flush, EX_MEM_Flush, MD_Busy, MD_Done
    localparam logic [7:0] O_IDLE   = 8'b1101_0000;
    localparam logic [7:0] O_MDSTRT = 8'b0000_0100;
    localparam logic [7:0] O_MDBUSY = 8'b0000_0110;
    localparam logic [7:0] O_MDDONE = 8'b1101_0001;
    localparam logic [7:0] O_LDUSE  = 8'b0001_1000;
    localparam logic [7:0] O_BRFL   = 8'b1111_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_use = 1'b0;
    logic B_Taken  = 1'b0;
    logic E_MD     = 1'b0;

    logic [7:0]  ov [NI];
    logic [31:0] sc [NI];
    logic [31:0] fc [NI];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            pipe_stall_ctrl #(.MD_LAT(LATS[gi])) u_dut (
                .clk          (clk),
                .rst          (rst),
                .load_use     (load_use),
                .B_Taken      (B_Taken),
                .E_MD         (E_MD),
                .PC_En        (ov[gi][7]),
                .IF_ID_En     (ov[gi][6]),
                .IF_ID_Flush  (ov[gi][5]),
                .ID_EX_En     (ov[gi][4]),
                .ID_EX_Flush  (ov[gi][3]),
                .EX_MEM_Flush (ov[gi][2]),
                .MD_Busy      (ov[gi][1]),
                .MD_Done      (ov[gi][0]),
                .Stall_Cnt    (sc[gi]),
                .Flush_Cnt    (fc[gi])
            );
        end
    endgenerate

    int n_vec = 0;
    int n_err = 0;

    // Reference model: age = cycles since the multiply/divide entered EX (0 = none).
    int          age   [NI];
    logic [31:0] m_stl [NI];
    logic [31:0] m_fls [NI];
    logic [7:0]  smp   [NI];

    function automatic logic [7:0] model_out(int i, logic r, logic lu, logic bt, logic md);
        if (r)                       return O_IDLE;
        if (age[i] == LATS[i] - 1)   return O_MDDONE;
        if (age[i] > 0)              return O_MDBUSY;
        if (md)                      return O_MDSTRT;
        if (lu)                      return O_LDUSE;
        if (bt)                      return O_BRFL;
        return O_IDLE;
    endfunction

    function automatic logic [31:0] perf_exp(logic [31:0] v);
`ifdef PIPE_CTRL_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            age[i] = 0; m_stl[i] = '0; m_fls[i] = '0;
        end
    endtask

    // Apply one cycle of stimulus: check at negedge, advance model at posedge.
    task automatic step(input logic lu, input logic bt, input logic md, input string tag);
        logic [7:0] e [NI];
        load_use = lu; B_Taken = bt; E_MD = md;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            e[i] = model_out(i, 1'b0, lu, bt, md);
            smp[i] = ov[i];
            chk($sformatf("%s/lat%0d/out", tag, LATS[i]), {24'd0, ov[i]}, {24'd0, e[i]});
            chk($sformatf("%s/lat%0d/stall", tag, LATS[i]), sc[i], perf_exp(m_stl[i]));
            chk($sformatf("%s/lat%0d/flush", tag, LATS[i]), fc[i], perf_exp(m_fls[i]));
        end
        $display("%s lu=%0b bt=%0b md=%0b out4=%08b out2=%08b out6=%08b",
                 tag, lu, bt, md, ov[0], ov[1], ov[2]);
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (!e[i][7]) m_stl[i] = m_stl[i] + 1;
            if (e[i][5])  m_fls[i] = m_fls[i] + 1;
            if (age[i] > 0)  age[i] = (age[i] == LATS[i] - 1) ? 0 : age[i] + 1;
            else if (md)     age[i] = 1;
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s/lat%0d/out", tag, LATS[i]), {24'd0, ov[i]}, {24'd0, O_IDLE});
            chk($sformatf("%s/lat%0d/cnt", tag, LATS[i]), sc[i] | fc[i], 32'd0);
        end
        $display("%s reset out4=%08b", tag, ov[0]);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic       lu;
        logic       bt;
        logic       md;
        logic [7:0] exp4;
    } vec_t;

    vec_t tab [18];

    initial begin
        tab[0]  = '{0, 0, 0, O_IDLE};
        tab[1]  = '{1, 0, 0, O_LDUSE};
        tab[2]  = '{1, 1, 0, O_LDUSE};
        tab[3]  = '{0, 1, 0, O_BRFL};
        tab[4]  = '{0, 0, 1, O_MDSTRT};
        tab[5]  = '{1, 1, 1, O_MDBUSY};
        tab[6]  = '{0, 0, 0, O_MDBUSY};
        tab[7]  = '{1, 1, 0, O_MDDONE};
        tab[8]  = '{0, 0, 0, O_IDLE};
        tab[9]  = '{1, 1, 1, O_MDSTRT};
        tab[10] = '{0, 0, 1, O_MDBUSY};
        tab[11] = '{0, 0, 1, O_MDBUSY};
        tab[12] = '{0, 0, 1, O_MDDONE};
        tab[13] = '{0, 0, 1, O_MDSTRT};
        tab[14] = '{0, 0, 0, O_MDBUSY};
        tab[15] = '{0, 0, 0, O_MDBUSY};
        tab[16] = '{0, 1, 0, O_MDDONE};
        tab[17] = '{0, 1, 0, O_BRFL};

        model_reset();
        #1;
        do_reset("rst0");

        for (int k = 0; k < 18; k++) begin
            step(tab[k].lu, tab[k].bt, tab[k].md, $sformatf("tab%0d", k));
            chk($sformatf("tab%0d/exp4", k), {24'd0, smp[0]}, {24'd0, tab[k].exp4});
        end

        // Performance counters: one MD_LAT=4 multiply/divide plus one branch flush.
        do_reset("rst_perf");
        step(0, 0, 1, "perf0");
        step(0, 0, 0, "perf1");
        step(0, 0, 0, "perf2");
        step(0, 0, 0, "perf3");
        step(0, 1, 0, "perf4");
        step(0, 0, 0, "perf5");
`ifdef PIPE_CTRL_PERF_EN
        chk("perf/stall", sc[0], 32'd3);
        chk("perf/flush", fc[0], 32'd1);
`else
        chk("perf/stall", sc[0], 32'd0);
        chk("perf/flush", fc[0], 32'd0);
`endif

        // Back-to-back on MD_LAT=2: PC_En 0,1,0,1 and Done 0,1,0,1.
        do_reset("rst_b2b");
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, $sformatf("b2b%0d", k));
            chk($sformatf("b2b%0d/pc_en", k), {31'd0, smp[1][7]}, {31'd0, (k % 2) == 1});
            chk($sformatf("b2b%0d/done", k), {31'd0, smp[1][0]}, {31'd0, (k % 2) == 1});
        end
        step(0, 0, 0, "b2b4");

        // Reset in cycle 1 of an MD_LAT=6 sequence.
        do_reset("rst_mid");
        step(0, 0, 1, "mid0");
        E_MD = 1'b0;
        #2;
        chk("mid1/busy6", {24'd0, ov[2]}, {24'd0, O_MDBUSY});
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("mid1/lat%0d/rst_out", LATS[i]), {24'd0, ov[i]}, {24'd0, O_IDLE});
        end
        E_MD = 1'b1;
        #1;
        chk("mid1/rst_md_held", {24'd0, ov[2]}, {24'd0, O_IDLE});
        $display("mid1 rst asserted out6=%08b", ov[2]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        E_MD = 1'b0;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 7; k++) begin
            step(0, 0, 0, $sformatf("post%0d", k));
            chk($sformatf("post%0d/no_done", k), {31'd0, smp[2][0]}, 32'd0);
        end

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(5) == 0,
                 $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have parameter MD_LAT, default 4, meaning the total EX-stage occupancy in cycles of a multiply/divide instruction; the legal range is 2..15.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 load_use  input  1  load-use hazard flag from the load-use detector for the current ID/EX pair.
REQ-005 B_Taken  input  1  branch or jump resolved taken in ID this cycle.
REQ-006 E_MD  input  1  EX-stage instruction is a multi-cycle multiply/divide.
REQ-007 PC_En  output  1  PC write enable.
REQ-008 IF_ID_En  output  1  IF/ID register write enable.
REQ-009 IF_ID_Flush  output  1  IF/ID bubble insert.
REQ-010 ID_EX_En  output  1  ID/EX register write enable.
REQ-011 ID_EX_Flush  output  1  ID/EX bubble insert.
REQ-012 EX_MEM_Flush  output  1  EX/MEM bubble insert.
REQ-013 MD_Busy  output  1  high while a multiply/divide holds EX beyond its first cycle.
REQ-014 MD_Done  output  1  one-cycle pulse on the final EX cycle of a multiply/divide.
REQ-015 Stall_Cnt  output  32  stall-cycle performance counter; see Configuration.
REQ-016 Flush_Cnt  output  32  branch-flush performance counter; see Configuration.

Function
REQ-017 The FSM SHALL have states RUN and MD_WAIT, plus a 4-bit down-counter cnt.
REQ-018 In RUN with E_MD=1, the block SHALL hold PC_En=IF_ID_En=ID_EX_En=0 and EX_MEM_Flush=1, load cnt=MD_LAT-2, and go to MD_WAIT.
REQ-019 In MD_WAIT with cnt!=0, the block SHALL keep the same freeze/bubble outputs, keep MD_Busy=1, and decrement cnt.
REQ-020 In MD_WAIT with cnt==0, the block SHALL release all enables, drive EX_MEM_Flush=0 and MD_Done=1 for that cycle, and return to RUN.
REQ-021 The total freeze per multiply/divide SHALL be MD_LAT-1 cycles, and the EX occupancy SHALL be MD_LAT cycles.
REQ-022 E_MD SHALL be ignored in MD_WAIT.
REQ-023 Back-to-back multiply/divides SHALL start a new sequence in the cycle after MD_Done.
REQ-024 In RUN with E_MD=0 and load_use=1, the block SHALL drive PC_En=IF_ID_En=0 and ID_EX_Flush=1 for exactly the cycles load_use is high, with no state change.
REQ-025 In RUN with E_MD=0, load_use=0 and B_Taken=1, the block SHALL drive IF_ID_Flush=1 for one cycle and keep all enables at 1.
REQ-026 Priority SHALL be: multiply/divide freeze > load-use stall > branch flush; a suppressed B_Taken or load_use is simply re-evaluated when ID is released.
REQ-027 In RUN with no hazard, the block SHALL drive all enables=1, all flushes=0, and MD_Busy=MD_Done=0.
REQ-028 All outputs SHALL be combinational functions of state, cnt and the inputs, with no input-to-output registers.

Reset
REQ-029 Reset SHALL force state=RUN, cnt=0, Stall_Cnt=0 and Flush_Cnt=0.
REQ-030 During reset, outputs SHALL be PC_En=IF_ID_En=ID_EX_En=1, all flushes=0, MD_Busy=0 and MD_Done=0.
REQ-031 Reset asserted in MD_WAIT SHALL abort the sequence immediately with no MD_Done pulse.

Configuration
REQ-032 With macro PIPE_CTRL_PERF_EN defined, Stall_Cnt SHALL increment (wrapping) on every cycle with PC_En=0, and Flush_Cnt SHALL increment on every cycle with IF_ID_Flush=1.
REQ-033 Without PIPE_CTRL_PERF_EN, both counter ports SHALL still exist, tie to 0, and no counter flops SHALL be synthesized.

Structure
REQ-034 Shared package pipe_ctrl_pkg SHALL hold the state encodings (RUN=1'b0, MD_WAIT=1'b1), the default MD_LAT, and the counter width.
REQ-035 The down-counter SHALL be sub-module md_lat_counter (load, decrement, zero flag), instantiated once.

Verification
REQ-036 Single multiply/divide: MD_LAT=4, E_MD=1 at cycle 0 -> PC_En=0 in cycles 0-2, MD_Busy=1 in cycles 1-2, MD_Done=1 in cycle 3, PC_En=1 in cycle 3.
REQ-037 Load-use stall: load_use=1 for one cycle -> PC_En=0, IF_ID_En=0 and ID_EX_Flush=1 for exactly one cycle, then normal flow.
REQ-038 Simultaneous hazards: load_use=1 and B_Taken=1 in the same cycle -> IF_ID_Flush=0 that cycle; B_Taken held next cycle -> IF_ID_Flush=1.
REQ-039 Back-to-back multiply/divides: MD_LAT=2 with E_MD high for 4 cycles -> PC_En pattern 0,1,0,1 and MD_Done pulses in cycles 1 and 3.
REQ-040 Reset mid-operation: rst asserted in cycle 1 of an MD_LAT=6 sequence -> outputs at reset values immediately, no MD_Done, clean RUN after release.
REQ-041 Performance counters with PIPE_CTRL_PERF_EN: one multiply/divide (MD_LAT=4) plus one branch flush -> Stall_Cnt=3, Flush_Cnt=1; without the macro both read 0.
